// File: rtl/washing_machine_ctrl_param.sv
// rtl/washing_machine_ctrl_param.sv - self-timed washing machine controller
// Internal wash/rinse/spin timer, rinse passes, pause, fill/drain watchdogs and door fault.
module washing_machine_ctrl_param #(
  parameter int TW            = 16,
  parameter int WASH_CYCLES   = 100,
  parameter int RINSE_CYCLES  = 50,
  parameter int SPIN_CYCLES   = 80,
  parameter int FILL_TIMEOUT  = 200,
  parameter int DRAIN_TIMEOUT = 200,
  parameter int RW            = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          door_close,
  input  logic          filled,
  input  logic          detergent_added,
  input  logic          drained,
  input  logic [RW-1:0] rinse_cfg,
  output logic          door_lock,
  output logic          motor_on,
  output logic          fill_valve_on,
  output logic          drain_valve_on,
  output logic          soap_wash,
  output logic          water_wash,
  output logic          done,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [RW-1:0] rinse_left
);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL_SOAP, S_WASH, S_DRAIN_SOAP, S_FILL_RINSE,
    S_RINSE, S_DRAIN_RINSE, S_SPIN, S_DONE, S_FAULT
  } state_e;

  localparam logic [TW-1:0] WASH_LAST  = TW'(WASH_CYCLES - 1);
  localparam logic [TW-1:0] RINSE_LAST = TW'(RINSE_CYCLES - 1);
  localparam logic [TW-1:0] SPIN_LAST  = TW'(SPIN_CYCLES - 1);
  localparam logic [TW-1:0] FILL_LAST  = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rinse_left_q, rinse_left_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic          active, hold;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAULT);
  assign hold   = active && pause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      rinse_left_q <= '0;
      fault_code_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rinse_left_q <= rinse_left_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rinse_left_d = rinse_left_q;
    fault_code_d = fault_code_q;
    // Door opening beats every other transition, paused or not.
    if (active && !door_close) begin
      state_d      = S_FAULT;
      fault_code_d = 2'd3;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (start && door_close) begin
            state_d      = S_FILL_SOAP;
            rinse_left_d = rinse_cfg;
          end
        end
        S_FILL_SOAP: begin
          if (filled && detergent_added) begin
            state_d = S_WASH;
          end else if (timer_q == FILL_LAST) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd1;
          end
        end
        S_WASH: begin
          if (timer_q == WASH_LAST) state_d = S_DRAIN_SOAP;
        end
        S_DRAIN_SOAP: begin
          if (drained) begin
            state_d = (rinse_left_q == '0) ? S_SPIN : S_FILL_RINSE;
          end else if (timer_q == DRAIN_LAST) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd2;
          end
        end
        S_FILL_RINSE: begin
          if (filled) begin
            state_d = S_RINSE;
          end else if (timer_q == FILL_LAST) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd1;
          end
        end
        S_RINSE: begin
          if (timer_q == RINSE_LAST) state_d = S_DRAIN_RINSE;
        end
        S_DRAIN_RINSE: begin
          if (drained) begin
            rinse_left_d = (rinse_left_q == '0) ? '0 : rinse_left_q - RW'(1);
            state_d      = (rinse_left_q <= RW'(1)) ? S_SPIN : S_FILL_RINSE;
          end else if (timer_q == DRAIN_LAST) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd2;
          end
        end
        S_SPIN: begin
          if (timer_q == SPIN_LAST) state_d = S_DONE;
        end
        S_DONE: begin
          if (!start) state_d = S_IDLE;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (!hold && (timer_q != '1)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_valve_on  = 1'b0;
    drain_valve_on = 1'b0;
    soap_wash      = 1'b0;
    water_wash     = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    case (state_q)
      S_FILL_SOAP:   begin door_lock = 1'b1; fill_valve_on = 1'b1; soap_wash = 1'b1; end
      S_WASH:        begin door_lock = 1'b1; motor_on = 1'b1; soap_wash = 1'b1; end
      S_DRAIN_SOAP:  begin door_lock = 1'b1; drain_valve_on = 1'b1; end
      S_FILL_RINSE:  begin door_lock = 1'b1; fill_valve_on = 1'b1; water_wash = 1'b1; end
      S_RINSE:       begin door_lock = 1'b1; motor_on = 1'b1; water_wash = 1'b1; end
      S_DRAIN_RINSE: begin door_lock = 1'b1; drain_valve_on = 1'b1; end
      S_SPIN:        begin door_lock = 1'b1; motor_on = 1'b1; drain_valve_on = 1'b1; end
      S_DONE:        done = 1'b1;
      S_FAULT:       begin fault = 1'b1; door_lock = 1'b1; drain_valve_on = 1'b1; end
      default:       ;
    endcase
    // Pause stops every actuator but keeps the door latched and wash phase flags.
    if (hold) begin
      motor_on       = 1'b0;
      fill_valve_on  = 1'b0;
      drain_valve_on = 1'b0;
    end
  end

  assign fault_code = fault_code_q;
  assign rinse_left = rinse_left_q;

endmodule

// File: doc/washing_machine_ctrl_param.md
Name: washing_machine_ctrl_param

Overview:
Parametrised successor to the automatic washing machine controller. The fixed-sequence FSM that relied on external timeouts becomes a self-timed controller with these additions:
- internal wash/rinse/spin duration counters;
- a configurable number of rinse passes;
- pause/resume;
- fill/drain watchdog faults;
- door-open fault detection.
It sits between the front-panel/sensor inputs and the valve/motor drivers.

Parameters:
TW, 16, width of internal cycle timer
WASH_CYCLES, 100, clock cycles spent in WASH
RINSE_CYCLES, 50, clock cycles spent in each RINSE pass
SPIN_CYCLES, 80, clock cycles spent in SPIN
FILL_TIMEOUT, 200, max cycles waiting in any fill state before fault
DRAIN_TIMEOUT, 200, max cycles waiting in any drain state before fault
RW, 3, width of rinse-count input/counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level; begin cycle from IDLE, acknowledge DONE when dropped
pause  in  1  level; freeze current operation while high
door_close  in  1  door sensor, 1 = closed
filled  in  1  water level sensor, drum full
detergent_added  in  1  detergent sensor
drained  in  1  drum empty sensor
rinse_cfg  in  RW  number of rinse passes, sampled on IDLE->FILL_SOAP
door_lock  out  1  door latch engaged
motor_on  out  1  drum motor running
fill_valve_on  out  1  inlet valve open
drain_valve_on  out  1  drain valve open
soap_wash  out  1  high in FILL_SOAP/WASH
water_wash  out  1  high in FILL_RINSE/RINSE
done  out  1  cycle complete
fault  out  1  sticky fault flag
fault_code  out  2  0 none, 1 fill timeout, 2 drain timeout, 3 door opened
rinse_left  out  RW  remaining rinse passes

Behaviour:
- Reset (reset=0, async): state=IDLE, timer=0, rinse_left=0, fault=0, fault_code=0. All other outputs 0.
- Outputs are a Moore decode of the state register; they change on the same edge as the state.
- States and transitions, evaluated each rising edge when pause=0:
  - IDLE: start&door_close -> FILL_SOAP. Latch rinse_cfg into rinse_left.
  - FILL_SOAP: fill_valve_on, door_lock, soap_wash. filled&detergent_added -> WASH.
  - WASH: motor_on, door_lock, soap_wash. Timer reaches WASH_CYCLES-1 -> DRAIN_SOAP.
  - DRAIN_SOAP: drain_valve_on, door_lock. On drained: rinse_left==0 -> SPIN, else -> FILL_RINSE.
  - FILL_RINSE: fill_valve_on, door_lock, water_wash. filled -> RINSE.
  - RINSE: motor_on, door_lock, water_wash. Timer reaches RINSE_CYCLES-1 -> DRAIN_RINSE.
  - DRAIN_RINSE: drain_valve_on, door_lock. On drained: decrement rinse_left. If rinse_left was 1 -> SPIN, else -> FILL_RINSE.
  - SPIN: motor_on, drain_valve_on, door_lock. Timer reaches SPIN_CYCLES-1 -> DONE.
  - DONE: done=1, door unlocked. start==0 -> IDLE.
  - FAULT: fault=1, drain_valve_on=1, door_lock=1, motor off. Exit only via reset.
- Timer:
  - Cleared on every state change; increments by 1 per unpaused cycle.
  - Timed states therefore last exactly N unpaused cycles.
  - Timer saturates at all-ones and never wraps.
  - TW must hold max(parameter)-1.
- Watchdog:
  - In a fill state with the completion condition false when timer==FILL_TIMEOUT-1 -> FAULT, fault_code=1.
  - Drain states likewise with DRAIN_TIMEOUT -> FAULT, fault_code=2.
  - If the completion condition and the timeout fire in the same cycle, the condition wins.
- Door fault: door_close==0 in any state except IDLE/DONE/FAULT -> FAULT, fault_code=3. This has priority over all other transitions, including while paused.
- Pause: while pause=1 in an active state:
  - state and timer hold; motor_on, fill_valve_on and drain_valve_on are forced 0;
  - door_lock, soap_wash, water_wash and rinse_left hold.
  - Pause in IDLE/DONE/FAULT has no effect.
- start is ignored in all states except IDLE and DONE.
- rinse_cfg changes after sampling have no effect.
- Reset mid-cycle returns to IDLE immediately and all outputs drop asynchronously.

Test Plan:
(Parameters for all scenarios: WASH=4, RINSE=3, SPIN=5, FILL_TO=6, DRAIN_TO=6.)
1. Full cycle, rinse_cfg=2, sensors asserted 1 cycle after each fill/drain entry -> sequence FILL_SOAP, WASH (4 clk), DRAIN_SOAP, FILL_RINSE, RINSE (3 clk), DRAIN_RINSE ×2, SPIN (5 clk), DONE. rinse_left goes 2→1→0. done=1 until start drops.
2. rinse_cfg=0 -> DRAIN_SOAP goes directly to SPIN; water_wash is never 1.
3. filled never asserted in FILL_SOAP -> on the 6th cycle FAULT, fault=1, fault_code=1, drain_valve_on=1. Remains there until reset.
4. pause=1 for 10 cycles at WASH timer=2 -> motor_on=0 and timer holds at 2. After release, WASH lasts exactly 2 more cycles.
5. door_close=0 during RINSE (also while paused) -> next edge FAULT, fault_code=3.
6. reset pulsed low mid-SPIN -> all outputs 0 asynchronously; after release, state is IDLE and fault=0.
